// File: rtl/chk_pkg.sv
// Shared widths, defaults and state encoding for the D-cache write checker.
package chk_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DUR_W  = 16;
  localparam int unsigned ERR_W  = 8;
  localparam int unsigned OFF_W  = 6;

  localparam logic [DATA_W-1:0] END_MAGIC_DEF = 32'h0000_DEAD;
  localparam logic [DUR_W-1:0]  TIMEOUT_DEF   = 16'd10000;

  // Golden pattern: base plus a per-offset stride, distinct for all 64 offsets.
  localparam logic [DATA_W-1:0] GOLD_BASE = 32'hC0DE_0000;
  localparam logic [DATA_W-1:0] GOLD_STEP = 32'd4099;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

endpackage

// File: rtl/chk_golden_rom.sv
// Combinational expected-data lookup indexed by result offset.
module chk_golden_rom
  import chk_pkg::*;
(
  input  logic [OFF_W-1:0]  offset,
  output logic [DATA_W-1:0] data_c
);

  // Expected word for the given offset.
  always_comb begin
    data_c = GOLD_BASE + DATA_W'(offset) * GOLD_STEP;
  end

endmodule

// File: rtl/dcache_write_checker.sv
// Watches processor stores, scores a window of result words against golden
// data once the end marker (or timeout) arrives, and reports the error count.
module dcache_write_checker
  import chk_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CHK_BASE   = 30'd64,
  parameter int unsigned       NUM_CHECKS = 20,
  parameter logic [ADDR_W-1:0] END_ADDR   = 30'd127,
  parameter logic [DATA_W-1:0] END_MAGIC  = END_MAGIC_DEF,
  parameter logic [DUR_W-1:0]  TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] addr,
  input  logic [31:0] data,
  input  logic        wen,
  output logic [7:0]  error_num,
  output logic [15:0] duration,
  output logic        finish,
  output logic        timeout
);

  localparam int unsigned          AW1     = ADDR_W + 1;
  localparam logic [ADDR_W:0]      WIN_END = {1'b0, CHK_BASE} + AW1'(NUM_CHECKS);
  localparam logic [OFF_W-1:0]     LAST_IX = OFF_W'(NUM_CHECKS - 1);

  chk_state_e              state_q, state_d;
  logic [NUM_CHECKS-1:0]   written_q, written_d;
  logic [NUM_CHECKS-1:0]   pass_q, pass_d;
  logic [DUR_W-1:0]        duration_q, duration_d;
  logic [ERR_W-1:0]        error_num_q, error_num_d;
  logic                    timeout_q, timeout_d;
  logic                    finish_q, finish_d;
  logic [OFF_W-1:0]        scan_idx_q, scan_idx_d;

  logic                    in_window_c;
  logic                    marker_c;
  logic                    scan_ok_c;
  logic [OFF_W-1:0]        off_c;
  logic [DATA_W-1:0]       golden_c;

  // Decode the incoming store against the result window and the marker.
  always_comb begin
    in_window_c = (addr >= CHK_BASE) && ({1'b0, addr} < WIN_END);
    off_c       = OFF_W'(addr - CHK_BASE);
    marker_c    = wen && (addr == END_ADDR) && (data == END_MAGIC);
  end

  chk_golden_rom u_rom (
    .offset (off_c),
    .data_c (golden_c)
  );

  // Next-state, bookkeeping and scoring.
  always_comb begin
    state_d     = state_q;
    written_d   = written_q;
    pass_d      = pass_q;
    duration_d  = duration_q;
    error_num_d = error_num_q;
    timeout_d   = timeout_q;
    scan_idx_d  = scan_idx_q;
    finish_d    = (state_q == ST_DONE);
    scan_ok_c   = 1'b0;

    for (int i = 0; i < int'(NUM_CHECKS); i++) begin
      if (scan_idx_q == OFF_W'(i)) begin
        scan_ok_c = written_q[i] & pass_q[i];
      end
    end

    case (state_q)
      ST_RUN: begin
        if (duration_q != '1) begin
          duration_d = duration_q + DUR_W'(1);
        end
        if (wen && in_window_c) begin
          for (int i = 0; i < int'(NUM_CHECKS); i++) begin
            if (off_c == OFF_W'(i)) begin
              written_d[i] = 1'b1;
              pass_d[i]    = (data == golden_c);
            end
          end
        end
        // Timeout wins the flag even when the marker lands in the same cycle.
        if (duration_d == TIMEOUT) begin
          timeout_d  = 1'b1;
          state_d    = ST_SCAN;
          scan_idx_d = '0;
        end else if (marker_c) begin
          state_d    = ST_SCAN;
          scan_idx_d = '0;
        end
      end
      ST_SCAN: begin
        if (!scan_ok_c && (error_num_q != '1)) begin
          error_num_d = error_num_q + ERR_W'(1);
        end
        if (scan_idx_q == LAST_IX) begin
          state_d = ST_DONE;
        end else begin
          scan_idx_d = scan_idx_q + OFF_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      written_q   <= '0;
      pass_q      <= '0;
      duration_q  <= '0;
      error_num_q <= '0;
      timeout_q   <= 1'b0;
      finish_q    <= 1'b0;
      scan_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      written_q   <= written_d;
      pass_q      <= pass_d;
      duration_q  <= duration_d;
      error_num_q <= error_num_d;
      timeout_q   <= timeout_d;
      finish_q    <= finish_d;
      scan_idx_q  <= scan_idx_d;
    end
  end

  assign error_num = error_num_q;
  assign duration  = duration_q;
  assign finish    = finish_q;
  assign timeout   = timeout_q;

endmodule
